stream_gen: RTL and testbench

- Synthesisable, parametrised stream source; replaces file-driven behavioural sources in stream pipeline benches and on-chip self-test.
- Emits one frame of IMG_W x IMG_H pixels, LANES pixels per beat, over a valid/ready handshake, with last_out on the final beat.
- Optionally inserts pseudo-random bubbles, LFSR-driven, to stress downstream back-pressure logic.

---
 rtl/stream_gen.sv | 98 +++++++++
 tb/tb_stream_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stream_gen.sv
// stream_gen: framed pixel stream source over valid/ready; define STREAM_GEN_STALL_EN for LFSR-driven bubbles
module stream_gen #(
  parameter int DATA_W = 8,
  parameter int LANES = 1,
  parameter int IMG_W = 260,
  parameter int IMG_H = 258,
  parameter int GAP_W = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_in,
  input  logic                      stall_en,
  output logic [DATA_W*LANES-1:0]   data_out,
  output logic                      valid,
  input  logic                      ready,
  output logic                      last_out,
  input  logic                      stop_in,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               beat_cnt
);
  localparam int NBEATS = IMG_W * IMG_H / LANES;
  localparam int BW = $clog2(NBEATS + 1);
  typedef enum logic [2:0] {IDLE, DECIDE, GAP, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] b, b_nx;
  logic [31:0] cnt_nx;
  logic [DATA_W*LANES-1:0] pix;
  logic decide, stall, gap_end, last_b;
  assign last_b = b == BW'(NBEATS - 1);
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign pix[k*DATA_W +: DATA_W] = DATA_W'(32'(b_nx) * 32'(LANES) + 32'(k));
  end
`ifdef STREAM_GEN_STALL_EN
  logic [15:0] lfsr;
  logic [GAP_W:0] gap;
  assign stall = stall_en & lfsr[0];
  assign gap_end = gap == (GAP_W+1)'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
      gap <= '0;
    end else begin
      if (decide) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      gap <= decide ? (GAP_W+1)'(lfsr[GAP_W:1]) + (GAP_W+1)'(1)
           : state == GAP ? gap - (GAP_W+1)'(1) : gap;
    end
  end
`else
  logic unused_stall;
  assign stall = 1'b0;
  assign gap_end = 1'b1;
  assign unused_stall = stall_en;
`endif
  always_comb begin
    state_nx = state;
    b_nx = b;
    cnt_nx = beat_cnt;
    decide = 1'b0;
    case (state)
      IDLE: if (start_in) begin
        state_nx = DECIDE;
        b_nx = '0;
        cnt_nx = '0;
      end
      DECIDE: decide = 1'b1;
      GAP: state_nx = gap_end ? SEND : GAP;
      SEND: if (ready) begin
        cnt_nx = beat_cnt + 32'd1;
        state_nx = last_b ? DONE : SEND;
        b_nx = last_b ? b : b + BW'(1);
        decide = !last_b;
      end
      DONE: state_nx = stop_in ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
    if (decide) state_nx = stall ? GAP : SEND;
  end
  // data_out reloads from b_nx on every SEND cycle, so a held beat keeps its value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      b <= '0;
      beat_cnt <= '0;
      data_out <= '0;
    end else begin
      state <= state_nx;
      b <= b_nx;
      beat_cnt <= cnt_nx;
      if (state_nx == SEND) data_out <= pix;
    end
  end
  assign valid = state == SEND;
  assign last_out = valid && last_b;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_stream_gen.sv
// tb_stream_gen: random back-pressure frames on four configurations against a beat-level model
module tb_stream_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall_en = 1'b0;
  logic [3:0] start = '0, stop = '0, rdy = '0;
  logic [3:0] v, l, bz, dn;
  logic [15:0] d0;
  logic [7:0] d1, d2;
  logic [23:0] d3;
  logic [31:0] c0, c1, c2, c3;
  logic [1:0] sel = '0;
  logic [23:0] m_data;
  logic [31:0] m_cnt;
  logic m_valid, m_last, m_busy, m_done;
  logic [15:0] lf [4];
  int errs = 0, checks = 0, gaps = 0;
  always #5 clk = ~clk;
  stream_gen #(.IMG_W(4), .IMG_H(2), .LANES(2)) u0 (.clk(clk), .reset(reset), .start_in(start[0]),
    .stall_en(stall_en), .data_out(d0), .valid(v[0]), .ready(rdy[0]), .last_out(l[0]),
    .stop_in(stop[0]), .busy(bz[0]), .done(dn[0]), .beat_cnt(c0));
  stream_gen #(.IMG_W(1), .IMG_H(1), .LANES(1)) u1 (.clk(clk), .reset(reset), .start_in(start[1]),
    .stall_en(stall_en), .data_out(d1), .valid(v[1]), .ready(rdy[1]), .last_out(l[1]),
    .stop_in(stop[1]), .busy(bz[1]), .done(dn[1]), .beat_cnt(c1));
  stream_gen #(.IMG_W(20), .IMG_H(15), .LANES(1)) u2 (.clk(clk), .reset(reset), .start_in(start[2]),
    .stall_en(stall_en), .data_out(d2), .valid(v[2]), .ready(rdy[2]), .last_out(l[2]),
    .stop_in(stop[2]), .busy(bz[2]), .done(dn[2]), .beat_cnt(c2));
  stream_gen #(.IMG_W(10), .IMG_H(30), .LANES(3)) u3 (.clk(clk), .reset(reset), .start_in(start[3]),
    .stall_en(stall_en), .data_out(d3), .valid(v[3]), .ready(rdy[3]), .last_out(l[3]),
    .stop_in(stop[3]), .busy(bz[3]), .done(dn[3]), .beat_cnt(c3));
  always_comb begin
    m_data = sel == 2'd0 ? 24'(d0) : sel == 2'd1 ? 24'(d1) : sel == 2'd2 ? 24'(d2) : d3;
    m_cnt = sel == 2'd0 ? c0 : sel == 2'd1 ? c1 : sel == 2'd2 ? c2 : c3;
    m_valid = v[sel];
    m_last = l[sel];
    m_busy = bz[sel];
    m_done = dn[sel];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
  function automatic logic [23:0] pix(input int b, input int lanes);
    logic [23:0] r = '0;
    for (int k = 0; k < lanes; k++) r[k*8 +: 8] = 8'((b * lanes + k) % 256);
    return r;
  endfunction
  task automatic run_frame(input int i, input int n, input int lanes, input int pct, input int abort_at);
    int b = 0, run = 0, cyc = 0, g;
    bit fresh = 1'b1, held = 1'b0;
    sel = 2'(i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    while (b < n && b != abort_at && cyc < 20000) begin
      check("cnt", m_cnt, b);
      if (held) check("noretract", 32'(m_valid), 1);
      if (m_valid) begin
        if (fresh) begin
          g = 0;
`ifdef STREAM_GEN_STALL_EN
          if (stall_en && lf[i][0]) g = 1 + int'(lf[i][5:1]);
          lf[i] = lfsr_step(lf[i]);
`endif
          check("gap", run, g + (b == 0 ? 1 : 0));
          if (run > (b == 0 ? 1 : 0)) gaps++;
          fresh = 1'b0;
        end
        check("data", m_data, pix(b, lanes));
        check("last", m_last, b == n - 1);
        check("busy", m_busy, 1);
        rdy[i] = $urandom_range(99) < pct;
        held = !rdy[i];
        if (rdy[i]) begin
          b++;
          fresh = 1'b1;
          run = 0;
        end
      end else begin
        run++;
        held = 1'b0;
        rdy[i] = $urandom_range(99) < pct;
      end
      cyc++;
      @(negedge clk);
    end
    rdy[i] = 1'b0;
    check("beats", b, abort_at >= 0 ? abort_at : n);
  endtask
  task automatic end_frame(input int i, input int n, input int hold);
    check("done", m_done, 1);
    check("done_valid", m_valid, 0);
    check("done_last", m_last, 0);
    check("done_busy", m_busy, 1);
    check("done_cnt", m_cnt, n);
    for (int k = 0; k < hold; k++) begin
      start[i] = k[0];
      @(negedge clk);
      check("hold_done", m_done, 1);
      check("hold_valid", m_valid, 0);
    end
    start[i] = 1'b0;
    stop[i] = 1'b1;
    @(negedge clk);
    stop[i] = 1'b0;
    check("idle_done", m_done, 0);
    check("idle_busy", m_busy, 0);
    check("idle_cnt", m_cnt, n);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) lf[i] = 16'hACE1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_data", m_data, 0);
      check("rst_busy", m_busy, 0);
      check("rst_done", m_done, 0);
      check("rst_cnt", m_cnt, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(0, 4, 2, 100, -1);
    end_frame(0, 4, 20);
    run_frame(0, 4, 2, 50, -1);
    end_frame(0, 4, 0);
    run_frame(3, 100, 3, 60, -1);
    end_frame(3, 100, 0);
    run_frame(1, 1, 1, 100, -1);
    end_frame(1, 1, 0);
    stall_en = 1'b1;
    gaps = 0;
    run_frame(2, 300, 1, 70, -1);
    end_frame(2, 300, 0);
`ifdef STREAM_GEN_STALL_EN
    check("stall_seen", gaps > 0, 1);
`endif
    run_frame(2, 300, 1, 70, 10);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_cnt", m_cnt, 0);
    check("arst_busy", m_busy, 0);
    for (int i = 0; i < 4; i++) lf[i] = 16'hACE1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(2, 300, 1, 90, -1);
    end_frame(2, 300, 0);
    stall_en = 1'b0;
    run_frame(2, 300, 1, 80, -1);
    end_frame(2, 300, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
